// File: rtl/gray_to_binary_sync_if.sv
// Bundles the Gray-pointer input, clear strobe and decoded/status outputs
// of gray_to_binary_sync. The slave side is the decoder; the master side
// is whoever supplies the foreign-domain Gray value and reads the status.
interface gray_to_binary_sync_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     gray_in;
    logic                 err_clr;
    logic [WIDTH-1:0]     bin_out;
    logic                 bin_valid;
    logic                 step;
    logic [WIDTH-1:0]     delta;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output gray_in,
        output err_clr,
        input  bin_out,
        input  bin_valid,
        input  step,
        input  delta,
        input  err,
        input  err_count
    );

    modport slave (
        input  gray_in,
        input  err_clr,
        output bin_out,
        output bin_valid,
        output step,
        output delta,
        output err,
        output err_count
    );
endinterface

// File: rtl/gray_to_binary_sync.sv
// Receive side of a Gray-coded CDC path. The foreign Gray value runs
// through a plain flop chain, is decoded to binary, and every new sample
// is compared against the previous one: single-bit changes produce a step
// pulse, multi-bit changes are flagged as illegal (sticky err plus a
// saturating counter). All outputs come straight from flops.
// SYNC_STAGES is intended to be 2..4.
module gray_to_binary_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_to_binary_sync_if.slave bus
);

    localparam int FILL_CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                  state_reg,     state_next;
    logic [FILL_CNT_W-1:0]   fill_cnt_reg,  fill_cnt_next;
    logic [WIDTH-1:0]        prev_gray_reg, prev_gray_next;
    logic [WIDTH-1:0]        bin_out_reg,   bin_out_next;
    logic                    bin_valid_reg, bin_valid_next;
    logic                    step_reg,      step_next;
    logic [WIDTH-1:0]        delta_reg,     delta_next;
    logic                    err_reg,       err_next;
    logic [ERR_CNT_W-1:0]    err_count_reg, err_count_next;

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] sync_bin;
    logic [WIDTH-1:0] gray_diff;
    logic             single_bit;
    logic             multi_bit;

    // MSB passes through; each lower binary bit is the XOR of the binary
    // bit above it and the Gray bit at that position.
    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchroniser chain: bare flops only, nothing between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_last  = sync_reg[SYNC_STAGES-1];
    assign sync_bin   = gray_decode(sync_last);
    assign gray_diff  = sync_last ^ prev_gray_reg;
    assign single_bit = $onehot(gray_diff);
    assign multi_bit  = (gray_diff != '0) && !single_bit;

    // State and output registers; every output is taken from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILL;
            fill_cnt_reg  <= '0;
            prev_gray_reg <= '0;
            bin_out_reg   <= '0;
            bin_valid_reg <= 1'b0;
            step_reg      <= 1'b0;
            delta_reg     <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fill_cnt_reg  <= fill_cnt_next;
            prev_gray_reg <= prev_gray_next;
            bin_out_reg   <= bin_out_next;
            bin_valid_reg <= bin_valid_next;
            step_reg      <= step_next;
            delta_reg     <= delta_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    // Next-state logic: wait out the chain fill, then classify each sample.
    always_comb begin
        state_next     = state_reg;
        fill_cnt_next  = fill_cnt_reg;
        prev_gray_next = prev_gray_reg;
        bin_out_next   = bin_out_reg;
        bin_valid_next = bin_valid_reg;
        step_next      = 1'b0;
        delta_next     = delta_reg;
        err_next       = err_reg;
        err_count_next = err_count_reg;

        case (state_reg)
            FILL: begin
                // The chain still holds reset zeros until SYNC_STAGES edges
                // have passed; the first real sample is loaded without any
                // step/err judgement since there is nothing to compare to.
                if (fill_cnt_reg == FILL_CNT_W'(SYNC_STAGES)) begin
                    bin_out_next   = sync_bin;
                    prev_gray_next = sync_last;
                    bin_valid_next = 1'b1;
                    delta_next     = '0;
                    state_next     = TRACK;
                end else begin
                    fill_cnt_next = fill_cnt_reg + FILL_CNT_W'(1);
                end
            end

            TRACK, FAULT: begin
                prev_gray_next = sync_last;
                if (gray_diff != '0) begin
                    // Old binary is bin_out_reg: it always tracks prev_gray here.
                    bin_out_next = sync_bin;
                    delta_next   = sync_bin - bin_out_reg;
                end
                step_next = single_bit;
                if (multi_bit) begin
                    // A fresh fault beats a simultaneous clear.
                    err_next   = 1'b1;
                    state_next = FAULT;
                    if (err_count_reg != '1) begin
                        err_count_next = err_count_reg + ERR_CNT_W'(1);
                    end
                end else if ((state_reg == FAULT) && bus.err_clr) begin
                    err_next   = 1'b0;
                    state_next = TRACK;
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    assign bus.bin_out   = bin_out_reg;
    assign bus.bin_valid = bin_valid_reg;
    assign bus.step      = step_reg;
    assign bus.delta     = delta_reg;
    assign bus.err       = err_reg;
    assign bus.err_count = err_count_reg;

endmodule
